// File: rtl/iob_iob2wishbone_pkg.sv
// rtl/iob_iob2wishbone_pkg.sv - shared types and constants for the IOb to Wishbone bridge
package iob_iob2wishbone_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    localparam logic [7:0] WB_SEL_ALL = 8'hFF;

    // Number of BUS cycles a transfer may last before the watchdog aborts it.
    function automatic int timeout_limit(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/iob_iob2wishbone_watchdog.sv
// rtl/iob_iob2wishbone_watchdog.sv - transfer watchdog counter with restart and terminal flag
module iob_iob2wishbone_watchdog
    import iob_iob2wishbone_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk_i,
    input  logic cke_i,
    input  logic arst_n_i,
    input  logic start_i,
    input  logic en_i,
    output logic last_o
);

    // last_o flags the final permitted cycle, so the abort happens on the limit-th cycle.
    localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(timeout_limit(TIMEOUT_W) - 1);

    logic [TIMEOUT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
        end else if (cke_i) begin
            if (start_i) begin
                cnt_q <= '0;
            end else if (en_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/iob_iob2wishbone.sv
// rtl/iob_iob2wishbone.sv - IOb slave to Wishbone classic master bridge, one outstanding transfer
module iob_iob2wishbone
    import iob_iob2wishbone_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_n_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_ready_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    output logic                err_o
);

    localparam int SEL_W = DATA_W / 8;

    state_t state_q, state_d;
    logic   accept, wd_last, timeout, abort, done;
    logic   cyc_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    // Bus error outranks ack; the watchdog only fires when the slave stayed silent.
    always_comb begin
        state_d     = state_q;
        iob_ready_o = (state_q == ST_IDLE);
        accept      = iob_avalid_i & iob_ready_o;
        timeout     = wd_last & ~wb_ack_i & ~wb_err_i;
        abort       = wb_err_i | timeout;
        done        = wb_ack_i | abort;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUS;
            ST_BUS:  if (done)   state_d = ST_IDLE;
        endcase
    end

    iob_iob2wishbone_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .cke_i    (cke_i),
        .arst_n_i (arst_n_i),
        .start_i  (accept),
        .en_i     (state_q == ST_BUS),
        .last_o   (wd_last)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            wb_we_o      <= 1'b0;
            cyc_q        <= 1'b0;
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
            err_o        <= 1'b0;
        end else if (cke_i) begin
            iob_rvalid_o <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (accept) begin
                    wb_adr_o <= iob_addr_i;
                    wb_dat_o <= iob_wdata_i;
                    wb_we_o  <= |iob_wstrb_i;
                    wb_sel_o <= (|iob_wstrb_i) ? iob_wstrb_i : WB_SEL_ALL[SEL_W-1:0];
                    cyc_q    <= 1'b1;
                    err_o    <= 1'b0;
                end
            end else if (done) begin
                cyc_q        <= 1'b0;
                iob_rvalid_o <= ~wb_we_o;
                if (abort) begin
                    err_o <= 1'b1;
                end
                if (!wb_we_o) begin
                    iob_rdata_o <= abort ? '0 : wb_dat_i;
                end
            end
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;

endmodule
